// File: rtl/reset_sequence_broadcast_if.sv
// Channel-side bundle of reset_sequence_broadcast.
// master: the sequencer. It takes per-channel requests and drives the
//         per-channel clock, reset and clock enable, plus seq_done.
// slave : the consumer side. It drives the requests and sees the outputs.
// Signals:
//   chan_reset_req - per-channel single-cycle re-reset request
//   chan_en        - per-channel clock-enable request
//   out_clock      - per-channel copy of the sequencer clock
//   out_reset      - per-channel active-high reset, registered
//   out_clken      - per-channel clock enable, registered
//   seq_done       - high once the start-up release sequence has completed
interface reset_sequence_broadcast_if #(
    parameter int NUM_OUT = 6
);
    logic [NUM_OUT-1:0] chan_reset_req;
    logic [NUM_OUT-1:0] chan_en;
    logic [NUM_OUT-1:0] out_clock;
    logic [NUM_OUT-1:0] out_reset;
    logic [NUM_OUT-1:0] out_clken;
    logic               seq_done;

    modport master (
        input  chan_reset_req,
        input  chan_en,
        output out_clock,
        output out_reset,
        output out_clken,
        output seq_done
    );

    modport slave (
        output chan_reset_req,
        output chan_en,
        input  out_clock,
        input  out_reset,
        input  out_clken,
        input  seq_done
    );
endinterface

// File: rtl/reset_sequence_broadcast.sv
// Reset sequencer and broadcaster. It holds every channel in reset for
// HOLD_CYCLES. It then releases the channels one at a time, STAGGER_CYCLES
// apart, and after that re-resets single channels on request.
// Ports:
//   clock    - the only clock; out_clock copies it to every channel
//   reset_n  - synchronous active-low reset; it dominates everything else
//   in_reset - upstream reset, active-high, sampled synchronously; it
//              restarts the whole sequence
//   bus      - channel bundle (master side), see reset_sequence_broadcast_if
//
// state   | meaning
// --------+-------------------------------------------------------------
// HOLD    | all channels in reset, cnt counts the initial hold
// RELEASE | channels released in index order, cnt counts the stagger gap
// RUN     | sequence complete, per-channel re-resets timed by pc[i]
module reset_sequence_broadcast #(
    parameter int NUM_OUT        = 6,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_reset,
    reset_sequence_broadcast_if.master bus
);
    localparam int               IDX_W        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [15:0]      HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0]      STAGGER_LAST = 16'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t             state;
    logic [15:0]        cnt;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        pc [NUM_OUT];
    logic [NUM_OUT-1:0] out_reset_q;
    logic [NUM_OUT-1:0] out_clken_q;
    logic               seq_done_q;

    // out_clock is a plain copy of the clock and ignores both resets.
    assign bus.out_clock = {NUM_OUT{clock}};
    assign bus.out_reset = out_reset_q;
    assign bus.out_clken = out_clken_q;
    assign bus.seq_done  = seq_done_q;

    always_ff @(posedge clock) begin
        // in_reset gives the same result as reset_n. reset_n still takes
        // priority, because both branches load the same values.
        if (!reset_n || in_reset) begin
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                pc[i] <= '0;
            end
            out_reset_q <= '1;
            out_clken_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            // The enable is computed from the registered reset, so it lags
            // out_reset by one cycle in both directions.
            out_clken_q <= bus.chan_en & ~out_reset_q;

            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state          <= RELEASE;
                        cnt            <= '0;
                        idx            <= '0;
                        out_reset_q[0] <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    // idx names the channel released most recently. When
                    // it reaches the last channel, the sequence is complete.
                    if (idx == IDX_LAST) begin
                        state      <= RUN;
                        cnt        <= '0;
                        seq_done_q <= 1'b1;
                    end else if (cnt == STAGGER_LAST) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (i == int'(idx) + 1) begin
                                out_reset_q[i] <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        // A request during an active re-reset reloads pc,
                        // which extends the hold.
                        if (bus.chan_reset_req[i]) begin
                            out_reset_q[i] <= 1'b1;
                            pc[i]          <= '0;
                        end else if (out_reset_q[i]) begin
                            if (pc[i] == HOLD_LAST) begin
                                out_reset_q[i] <= 1'b0;
                            end else begin
                                pc[i] <= pc[i] + 16'd1;
                            end
                        end
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequence_broadcast.sv
module tb_reset_sequence_broadcast;
    logic clock = 1'b0;
    logic reset_n;
    logic in_reset;
    logic reset_n1;
    logic in_reset1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Hand-computed release edges for the default configuration.
    localparam int REL [6] = '{16, 20, 24, 28, 32, 36};

    reset_sequence_broadcast_if #(.NUM_OUT(6)) bus0 ();
    reset_sequence_broadcast_if #(.NUM_OUT(1)) bus1 ();

    reset_sequence_broadcast #(
        .NUM_OUT(6), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .in_reset(in_reset), .bus(bus0)
    );

    reset_sequence_broadcast #(
        .NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n1), .in_reset(in_reset1), .bus(bus1)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] exp_rst(input int e, input int base);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (e < base + REL[i]);
        return r;
    endfunction

    function automatic logic [5:0] exp_clken(input int e, input int base);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (e >= base + REL[i] + 1);
        return r;
    endfunction

    function automatic logic [5:0] exp_clken_rr(input int k, input int first, input int last,
                                                input logic [5:0] ch);
        return (k >= first && k <= last) ? ~ch : 6'h3F;
    endfunction

    initial begin
        int base;

        reset_n   = 1'b0;
        in_reset  = 1'b0;
        reset_n1  = 1'b0;
        in_reset1 = 1'b0;
        bus0.chan_en        = 6'h3F;
        bus0.chan_reset_req = 6'h00;
        bus1.chan_en        = 1'b1;
        bus1.chan_reset_req = 1'b0;

        // Reset values, and out_clock following the clock during reset.
        repeat (3) step();
        check_val("rst out_reset",   bus0.out_reset, 6'h3F);
        check_val("rst out_clken",   bus0.out_clken, 6'h00);
        check_val("rst seq_done",    bus0.seq_done,  1'b0);
        check_val("rst1 out_reset",  bus1.out_reset, 1'b1);
        check_val("rst1 seq_done",   bus1.seq_done,  1'b0);
        check_val("rst clk high",    bus0.out_clock, 6'h3F);
        @(negedge clock);
        #1;
        check_val("rst clk low",     bus0.out_clock, 6'h00);
        step();

        // Start-up sequence from edge 1.
        reset_n  = 1'b1;
        reset_n1 = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            check_val($sformatf("seq rst e%0d", e),   bus0.out_reset, exp_rst(e, 0));
            check_val($sformatf("seq clken e%0d", e), bus0.out_clken, exp_clken(e, 0));
            check_val($sformatf("seq done e%0d", e),  bus0.seq_done,  (e >= 37));
            if (e <= 3) begin
                check_val($sformatf("n1 rst e%0d", e),   bus1.out_reset, 1'b0);
                check_val($sformatf("n1 done e%0d", e),  bus1.seq_done,  (e >= 2));
                check_val($sformatf("n1 clken e%0d", e), bus1.out_clken, (e >= 2));
            end
        end

        // Single re-reset of channel 2.
        for (int k = 1; k <= 20; k++) begin
            bus0.chan_reset_req = (k == 1) ? 6'h04 : 6'h00;
            step();
            check_val($sformatf("rr rst k%0d", k),   bus0.out_reset, (k <= 16) ? 6'h04 : 6'h00);
            check_val($sformatf("rr clken k%0d", k), bus0.out_clken, exp_clken_rr(k, 2, 17, 6'h04));
            check_val($sformatf("rr done k%0d", k),  bus0.seq_done,  1'b1);
        end

        // Channel 1 requested twice, 5 cycles apart: 21 cycles high.
        for (int k = 1; k <= 24; k++) begin
            bus0.chan_reset_req = (k == 1 || k == 6) ? 6'h02 : 6'h00;
            step();
            check_val($sformatf("ext rst k%0d", k),   bus0.out_reset, (k <= 21) ? 6'h02 : 6'h00);
            check_val($sformatf("ext clken k%0d", k), bus0.out_clken, exp_clken_rr(k, 2, 22, 6'h02));
        end

        // in_reset sampled at edge 23 restarts the sequence.
        // The request at edge 30 arrives during HOLD and must be ignored.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            in_reset            = (e == 23);
            bus0.chan_reset_req = (e == 30) ? 6'h08 : 6'h00;
            step();
            base = (e >= 23) ? 23 : 0;
            check_val($sformatf("inr rst e%0d", e),   bus0.out_reset, exp_rst(e, base));
            check_val($sformatf("inr clken e%0d", e), bus0.out_clken, exp_clken(e, base));
            check_val($sformatf("inr done e%0d", e),  bus0.seq_done,  (e >= 60));
        end
        in_reset = 1'b0;

        // reset_n in RUN, with a request in the same cycle.
        reset_n             = 1'b0;
        bus0.chan_reset_req = 6'h01;
        step();
        check_val("rn out_reset", bus0.out_reset, 6'h3F);
        check_val("rn out_clken", bus0.out_clken, 6'h00);
        check_val("rn seq_done",  bus0.seq_done,  1'b0);
        reset_n             = 1'b1;
        bus0.chan_reset_req = 6'h00;
        for (int e = 1; e <= 16; e++) begin
            step();
            check_val($sformatf("rn2 rst e%0d", e),  bus0.out_reset, exp_rst(e, 0));
            check_val($sformatf("rn2 done e%0d", e), bus0.seq_done,  1'b0);
        end

        // Re-reset on the single-channel instance: one cycle high.
        bus1.chan_reset_req = 1'b1;
        step();
        check_val("n1 rr rst on",  bus1.out_reset, 1'b1);
        bus1.chan_reset_req = 1'b0;
        step();
        check_val("n1 rr rst off", bus1.out_reset, 1'b0);
        check_val("n1 rr done",    bus1.seq_done,  1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reset_sequence_broadcast.md
RESET_SEQUENCE_BROADCAST -- requirements
Module: reset_sequence_broadcast

Interface
REQ-001 Parameter NUM_OUT, default 6: number of output clock/reset channels; legal range 1..32.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum reset-assertion length in cycles; legal range 1..65535.
REQ-003 Parameter STAGGER_CYCLES, default 4: spacing in cycles between successive channel releases; legal range 1..65535.
REQ-004 Port clock, input, width 1: the only clock; all state SHALL be updated on its rising edge.
REQ-005 Port reset_n, input, width 1: reset, synchronous and active-low.
REQ-006 Port in_reset, input, width 1: upstream domain reset, active-high, sampled synchronously.
REQ-007 Port chan_reset_req, input, width NUM_OUT: per-channel single-cycle re-reset request.
REQ-008 Port chan_en, input, width NUM_OUT: per-channel clock-enable request.
REQ-009 Port out_clock, output, width NUM_OUT: every bit SHALL be combinationally equal to clock.
REQ-010 Port out_reset, output, width NUM_OUT: per-channel reset, active-high, registered.
REQ-011 Port out_clken, output, width NUM_OUT: per-channel clock enable, registered.
REQ-012 Port seq_done, output, width 1: registered; high while the start-up sequence is complete.

Function
REQ-013 Controller FSM states SHALL be HOLD, RELEASE and RUN.
REQ-014 FSM uses a shared counter cnt (16 bits) and a channel index idx (ceil(log2(NUM_OUT)) bits, minimum 1 bit).
REQ-015 HOLD: cnt SHALL increment each cycle; at cnt == HOLD_CYCLES-1, go to RELEASE with cnt=0, idx=0, and clear out_reset[0] on that same edge.
REQ-016 RELEASE: cnt SHALL increment each cycle; at cnt == STAGGER_CYCLES-1, clear out_reset[idx+1], increment idx, and set cnt=0.
REQ-017 RELEASE exit: once channel NUM_OUT-1 is cleared, go to RUN on the next edge and set seq_done=1.
REQ-018 NUM_OUT=1: the FSM SHALL pass HOLD -> RELEASE -> RUN, with seq_done one cycle after out_reset[0] falls.
REQ-019 Release timing: out_reset[i] SHALL fall at edge HOLD_CYCLES + i*STAGGER_CYCLES, counting edge 1 as the first edge with reset_n sampled high and in_reset low.
REQ-020 Release timing: seq_done SHALL rise one edge after out_reset[NUM_OUT-1] falls.
REQ-021 RUN, re-reset request: chan_reset_req[i]=1 SHALL set out_reset[i]=1 on the next edge and load per-channel counter pc[i]=0.
REQ-022 RUN, re-reset hold: pc[i] SHALL count up and out_reset[i] SHALL clear on the edge where pc[i] == HOLD_CYCLES-1, giving HOLD_CYCLES cycles high.
REQ-023 A chan_reset_req[i] arriving while channel i is already re-resetting SHALL reload pc[i]=0, extending the hold.
REQ-024 chan_reset_req SHALL be ignored in HOLD and RELEASE.
REQ-025 Channels SHALL re-reset independently; simultaneous requests on several channels SHALL all be honoured in the same cycle.
REQ-026 seq_done SHALL stay 1 during per-channel re-resets.
REQ-027 out_clken[i] SHALL be registered as chan_en[i] AND NOT out_reset[i] (current register value), giving one cycle latency from either input.
REQ-028 in_reset=1, any state: on the next edge the block SHALL enter HOLD with cnt=0, all out_reset=1, all out_clken=0 and seq_done=0.
REQ-029 While in_reset stays 1, the block SHALL remain in HOLD with cnt held at 0.
REQ-030 Counter arithmetic SHALL be unsigned and SHALL never wrap, because every compare terminates the count.

Reset
REQ-031 reset_n=0 sampled at an edge SHALL set state=HOLD, cnt=0, idx=0, all pc=0, out_reset all ones, out_clken all zeros, seq_done=0.
REQ-032 reset_n SHALL dominate in_reset and chan_reset_req.
REQ-033 reset_n asserted mid-sequence or mid-re-reset SHALL abort the operation and apply the REQ-031 values on the same edge.
REQ-034 out_clock SHALL be unaffected by either reset.

Verification
REQ-035 Scenario, defaults: release reset_n at edge 0 -> out_reset[0..5] fall at edges 16, 20, 24, 28, 32, 36; seq_done rises at edge 37.
REQ-036 Scenario, re-reset: in RUN with chan_en=6'h3F, pulse chan_reset_req=6'b000100 -> out_reset[2] high 16 cycles; out_clken[2] low from the edge after request through one edge after release; other channels unchanged.
REQ-037 Scenario, extended hold: pulse chan_reset_req[1] twice, 5 cycles apart -> out_reset[1] high 21 cycles total.
REQ-038 Scenario, in_reset mid-sequence: assert in_reset for 1 cycle at edge 22 -> out_reset returns to 6'h3F at edge 23; full sequence restarts; seq_done rises 37 edges after in_reset drops.
REQ-039 Scenario, reset_n mid-run: drive reset_n=0 for one cycle in RUN -> all outputs take reset values on that edge; chan_reset_req asserted in the same cycle has no effect.
REQ-040 Scenario, NUM_OUT=1, HOLD_CYCLES=1, STAGGER_CYCLES=1 -> out_reset[0] falls at edge 1; seq_done rises at edge 2.
